// File: rtl/spi_flash_responder_if.sv
// Pin and memory-port bundle for the SPI flash READ responder.
// slave is the responder's view; master is the SPI host plus memory side.
interface spi_flash_responder_if #(
  parameter int unsigned ADDR_W = 24
);
  logic              cs_n;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              active;
  logic              err_cmd;

  modport slave (
    input  cs_n, sclk, mosi, mem_data,
    output miso, miso_oe, mem_rd, mem_addr, active, err_cmd
  );

  modport master (
    output cs_n, sclk, mosi, mem_data,
    input  miso, miso_oe, mem_rd, mem_addr, active, err_cmd
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 responder emulating a serial-flash READ (0x03): oversampled pins,
// 8-bit opcode + 24-bit address, then prefetched bytes streamed MSB-first.
module spi_flash_responder #(
  parameter int unsigned ADDR_W   = 24,
  parameter logic [7:0]  CMD_READ = 8'h03
) (
  input logic                  clk,
  input logic                  rst,
  spi_flash_responder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic       sclk_hist_q;
  logic       sclk_s, mosi_s, sel, rise, fall;

  logic        armed_q, armed_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [6:0]  cmd_sr_q, cmd_sr_d;
  logic [22:0] addr_sr_q, addr_sr_d;
  logic [23:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  buf_q, buf_d;
  logic        buf_valid_q, buf_valid_d;
  logic [7:0]  tx_sr_q, tx_sr_d;
  logic        rd_pend_q, rd_pend_d;

  logic        mem_rd_c;
  logic [23:0] rd_addr_c;
  logic        err_c;

  // cs_n synchronizer resets to "selected" so a cs_n held low through reset
  // release cannot be mistaken for a fresh select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[0], bus.cs_n};
      mosi_sync_q <= {mosi_sync_q[0], bus.mosi};
      sclk_hist_q <= sclk_sync_q[1];
    end
  end

  assign sclk_s = sclk_sync_q[1];
  assign mosi_s = mosi_sync_q[1];
  assign sel    = ~cs_sync_q[1];
  assign rise   = sclk_s & ~sclk_hist_q;
  assign fall   = ~sclk_s & sclk_hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      cmd_sr_q    <= '0;
      addr_sr_q   <= '0;
      rd_ptr_q    <= '0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      tx_sr_q     <= '0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      cmd_sr_q    <= cmd_sr_d;
      addr_sr_q   <= addr_sr_d;
      rd_ptr_q    <= rd_ptr_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      tx_sr_q     <= tx_sr_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q | ~sel;
    cnt_d       = cnt_q;
    cmd_sr_d    = cmd_sr_q;
    addr_sr_d   = addr_sr_q;
    rd_ptr_d    = rd_ptr_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    tx_sr_d     = tx_sr_q;
    mem_rd_c    = 1'b0;
    rd_addr_c   = '0;
    err_c       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d       = '0;
        cmd_sr_d    = '0;
        addr_sr_d   = '0;
        buf_valid_d = 1'b0;
        tx_sr_d     = '0;
        if (sel && armed_q) state_d = S_CMD;
      end

      S_CMD: begin
        if (rise) begin
          cmd_sr_d = {cmd_sr_q[5:0], mosi_s};
          if (cnt_q == 5'd7) begin
            cnt_d = '0;
            if ({cmd_sr_q, mosi_s} == CMD_READ) begin
              state_d = S_ADDR;
            end else begin
              err_c   = 1'b1;
              state_d = S_IGNORE;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      S_ADDR: begin
        if (rise) begin
          addr_sr_d = {addr_sr_q[21:0], mosi_s};
          if (cnt_q == 5'd23) begin
            rd_ptr_d  = {addr_sr_q, mosi_s};
            rd_addr_c = {addr_sr_q, mosi_s};
            mem_rd_c  = 1'b1;
            cnt_d     = '0;
            state_d   = S_DATA;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      S_DATA: begin
        if (fall) begin
          if (cnt_q[2:0] == 3'd0) begin
            tx_sr_d     = buf_valid_q ? buf_q : '0;
            buf_valid_d = 1'b0;
            rd_ptr_d    = rd_ptr_q + 24'd1;
            rd_addr_c   = rd_ptr_q + 24'd1;
            mem_rd_c    = 1'b1;
            cnt_d       = 5'd1;
          end else begin
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
            cnt_d   = {2'b00, cnt_q[2:0] + 3'd1};
          end
        end
        // Prefetch return lands here; it never coincides with a byte load.
        if (rd_pend_q) begin
          buf_d       = bus.mem_data;
          buf_valid_d = 1'b1;
        end
      end

      S_IGNORE: begin
      end

      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && !sel) begin
      state_d     = S_IDLE;
      mem_rd_c    = 1'b0;
      buf_valid_d = 1'b0;
    end
  end

  assign rd_pend_d = mem_rd_c;

  assign bus.mem_rd   = mem_rd_c;
  assign bus.mem_addr = mem_rd_c ? rd_addr_c[ADDR_W-1:0] : '0;
  assign bus.err_cmd  = err_c;
  assign bus.active   = (state_q != S_IDLE);
  assign bus.miso_oe  = (state_q == S_DATA);
  assign bus.miso     = (state_q == S_DATA) & tx_sr_q[7];

endmodule
